// File: rtl/cim_pkg.sv
// Shared types for the CIM activation path: serializer FSM states and control tokens.
// ACT_SERIALIZER_SIGNED_EN adds the neg field to the token.
package cim_pkg;

  localparam int unsigned SHIFT_DLY_DEF = 2;
  localparam int unsigned TOK_SHIFT_W   = 8;

  typedef enum logic [1:0] {
    ACT_SER_IDLE,
    ACT_SER_CLEAR,
    ACT_SER_SHIFT
  } act_ser_state_e;

  typedef struct packed {
    logic [TOK_SHIFT_W-1:0] shift;
    logic                   clr;
`ifdef ACT_SERIALIZER_SIGNED_EN
    logic                   neg;
`endif
    logic                   last;
  } act_ser_tok_t;

endpackage

// File: rtl/ctrl_delay.sv
// SHIFT_DLY-stage control token pipeline aligning serializer tokens with the accumulator.
// A parallel live bit per stage tracks non-idle slots, since a shift=0 token is otherwise all-zero.
module ctrl_delay import cim_pkg::*; #(
  parameter int unsigned SHIFT_DLY = SHIFT_DLY_DEF
) (
  input  logic         clock,
  input  logic         resetn,
  input  act_ser_tok_t tok_i,
  input  logic         live_i,
  output act_ser_tok_t tok_o,
  output logic         any_live_o
);

  act_ser_tok_t           tok_q [SHIFT_DLY];
  act_ser_tok_t           tok_d [SHIFT_DLY];
  logic [SHIFT_DLY-1:0]   live_q, live_d;

  always_comb begin
    tok_d[0]  = tok_i;
    live_d    = '0;
    live_d[0] = live_i;
    for (int unsigned i = 1; i < SHIFT_DLY; i++) begin
      tok_d[i]  = tok_q[i-1];
      live_d[i] = live_q[i-1];
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < SHIFT_DLY; i++) tok_q[i] <= '0;
      live_q <= '0;
    end else begin
      for (int unsigned i = 0; i < SHIFT_DLY; i++) tok_q[i] <= tok_d[i];
      live_q <= live_d;
    end
  end

  assign tok_o      = tok_q[SHIFT_DLY-1];
  assign any_live_o = |live_q;

endmodule

// File: rtl/act_serializer.sv
// Bit-serial activation transmitter: LSB-first ia rows plus aligned accumulator controls.
// ACT_SERIALIZER_SIGNED_EN: two's-complement activations, acc_neg on the MSB slot.
module act_serializer import cim_pkg::*; #(
  parameter int unsigned WORDLEN       = 8,
  parameter int unsigned ACT_BITS      = 8,
  parameter int unsigned LOG2_ACT_BITS = 3,
  parameter int unsigned NROWS         = 128,
  parameter int unsigned SHIFT_DLY     = SHIFT_DLY_DEF
) (
  input  logic                               clock,
  input  logic                               resetn,
  input  logic [NROWS-1:0][ACT_BITS-1:0]     act_data,
  input  logic                               act_valid,
  output logic                               act_ready,
  output logic [NROWS-1:0]                   ia,
  output logic [WORDLEN-1:0]                 shift,
  output logic                               acc_clr,
  output logic                               acc_neg,
  output logic                               sum_valid,
  output logic                               busy
);

  localparam logic [LOG2_ACT_BITS-1:0] CNT_LAST = LOG2_ACT_BITS'(ACT_BITS - 1);

  act_ser_state_e                 state_q, state_d;
  logic [LOG2_ACT_BITS-1:0]       cnt_q, cnt_d;
  logic [NROWS-1:0][ACT_BITS-1:0] sr_q, sr_d;
  logic [NROWS-1:0]               ia_q, ia_d;
  logic                           sum_valid_q, sum_valid_d;
  logic                           last_slot, take, tok_live, dly_live;
  act_ser_tok_t                   tok_in, tok_out;

  always_comb begin
    last_slot = (state_q == ACT_SER_SHIFT) && (cnt_q == CNT_LAST);
    act_ready = (state_q == ACT_SER_IDLE) || last_slot;
    take      = act_ready && act_valid;

    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    ia_d    = '0;

    unique case (state_q)
      ACT_SER_IDLE:  if (take) state_d = ACT_SER_CLEAR;
      ACT_SER_CLEAR: begin
        state_d = ACT_SER_SHIFT;
        cnt_d   = '0;
      end
      ACT_SER_SHIFT: begin
        if (!last_slot) cnt_d = cnt_q + 1'b1;
        else            state_d = take ? ACT_SER_CLEAR : ACT_SER_IDLE;
      end
      default:       state_d = ACT_SER_IDLE;
    endcase

    if (take) sr_d = act_data;

    // ia is registered together with the state, so it presents the bit of the slot being entered
    if (state_d == ACT_SER_SHIFT) begin
      for (int unsigned r = 0; r < NROWS; r++) begin
        ia_d[r] = sr_q[r][0];
        sr_d[r] = {1'b0, sr_q[r][ACT_BITS-1:1]};
      end
    end

    tok_in     = '0;
    tok_in.clr = (state_q == ACT_SER_CLEAR);
    if (state_q == ACT_SER_SHIFT) begin
      tok_in.shift = TOK_SHIFT_W'(cnt_q);
      tok_in.last  = last_slot;
`ifdef ACT_SERIALIZER_SIGNED_EN
      tok_in.neg   = last_slot;
`endif
    end
    tok_live = (state_q != ACT_SER_IDLE);

    sum_valid_d = tok_out.last;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ACT_SER_IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      ia_q        <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      ia_q        <= ia_d;
      sum_valid_q <= sum_valid_d;
    end
  end

  ctrl_delay #(.SHIFT_DLY(SHIFT_DLY)) u_ctrl_delay (
    .clock      (clock),
    .resetn     (resetn),
    .tok_i      (tok_in),
    .live_i     (tok_live),
    .tok_o      (tok_out),
    .any_live_o (dly_live)
  );

  assign ia        = ia_q;
  assign shift     = WORDLEN'(tok_out.shift);
  assign acc_clr   = tok_out.clr;
`ifdef ACT_SERIALIZER_SIGNED_EN
  assign acc_neg   = tok_out.neg;
`else
  assign acc_neg   = 1'b0;
`endif
  assign sum_valid = sum_valid_q;
  assign busy      = (state_q != ACT_SER_IDLE) || dly_live;

endmodule
